// File: rtl/voting_pkg.sv
// Shared constants and the FSM state type for the voting collector.
package voting_pkg;

  localparam int N          = 1;
  localparam int M          = 4;
  localparam int MAX_VOTERS = (1 << M) - 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_REPORT  = 2'd2
  } state_t;

endpackage

// File: rtl/voting_decide.sv
// Combinational outcome: the motion carries only when enabled and yes strictly beats no.
module voting_decide #(
  parameter int M = voting_pkg::M
) (
  input  logic         en,
  input  logic [M-1:0] yes,
  input  logic [M-1:0] no,
  output logic         win
);

  assign win = en & (yes > no);

endmodule

// File: rtl/voting_collector_n1_m4.sv
// Ballot collector: opens an election, tallies unique yes/no ballots, rejects
// duplicates and the reserved id 0, then holds the result until it is consumed.
module voting_collector_n1_m4 #(
  parameter int N = voting_pkg::N,
  parameter int M = voting_pkg::M
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         open_i,
  input  logic         en_i,
  input  logic         close_i,
  input  logic         bal_valid_i,
  output logic         bal_ready_o,
  input  logic [M-1:0] bal_id_i,
  input  logic [N-1:0] bal_vote_i,
  output logic         res_valid_o,
  input  logic         res_ready_i,
  output logic         res_win_o,
  output logic [M-1:0] res_yes_o,
  output logic [M-1:0] res_no_o,
  output logic [M-1:0] res_rej_o,
  output logic         busy_o
);

  import voting_pkg::*;

  localparam int             MAXV    = (1 << M) - 1;
  localparam logic [M-1:0]   CNT_MAX = M'(MAXV);
  localparam logic [M:0]     ALL_IDS = (M+1)'(MAXV);

  state_t          state_reg, state_next;
  logic [M-1:0]    yes_reg, yes_next;
  logic [M-1:0]    no_reg, no_next;
  logic [M-1:0]    rej_reg, rej_next;
  logic [MAXV:1]   seen_reg, seen_next;
  logic            en_reg, en_next;

  logic [MAXV:1]   id_hit;
  logic            dup;
  logic            fresh;
  logic [M:0]      unique_after;
  logic            last_unique;
  logic            decide_win;

  // One-hot decode of the ballot id; id 0 decodes to nothing.
  genvar gi;
  generate
    for (gi = 1; gi <= MAXV; gi++) begin : g_id_hit
      assign id_hit[gi] = (bal_id_i == M'(gi));
    end
  endgenerate

  assign dup          = |(id_hit & seen_reg);
  assign fresh        = (bal_id_i != '0) && !dup;
  assign unique_after = {1'b0, yes_reg} + {1'b0, no_reg} + (M+1)'(1);
  assign last_unique  = fresh && (unique_after == ALL_IDS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      yes_reg   <= '0;
      no_reg    <= '0;
      rej_reg   <= '0;
      seen_reg  <= '0;
      en_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      yes_reg   <= yes_next;
      no_reg    <= no_next;
      rej_reg   <= rej_next;
      seen_reg  <= seen_next;
      en_reg    <= en_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    yes_next   = yes_reg;
    no_next    = no_reg;
    rej_next   = rej_reg;
    seen_next  = seen_reg;
    en_next    = en_reg;
    case (state_reg)
      ST_IDLE: begin
        if (open_i) begin
          state_next = ST_COLLECT;
          yes_next   = '0;
          no_next    = '0;
          rej_next   = '0;
          seen_next  = '0;
          en_next    = en_i;
        end
      end
      ST_COLLECT: begin
        if (bal_valid_i) begin
          if (fresh) begin
            seen_next = seen_reg | id_hit;
            if (bal_vote_i[0]) yes_next = yes_reg + M'(1);
            else               no_next  = no_reg + M'(1);
          end else if (rej_reg != CNT_MAX) begin
            rej_next = rej_reg + M'(1);
          end
        end
        // A ballot arriving with close_i is tallied above before closing.
        if (close_i || (bal_valid_i && last_unique)) state_next = ST_REPORT;
      end
      ST_REPORT: begin
        if (res_ready_i) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  voting_decide #(.M(M)) u_decide (
    .en  (en_reg),
    .yes (yes_reg),
    .no  (no_reg),
    .win (decide_win)
  );

  assign bal_ready_o = (state_reg == ST_COLLECT);
  assign res_valid_o = (state_reg == ST_REPORT);
  assign busy_o      = (state_reg != ST_IDLE);
  assign res_win_o   = res_valid_o & decide_win;
  assign res_yes_o   = yes_reg;
  assign res_no_o    = no_reg;
  assign res_rej_o   = rej_reg;

endmodule

// File: tb/tb_voting_collector_n1_m4.sv
// Directed plus randomized bench for the voting collector against an election-level model.
module tb_voting_collector_n1_m4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       open_i = 1'b0;
  logic       en_i = 1'b0;
  logic       close_i = 1'b0;
  logic       bal_valid_i = 1'b0;
  logic       bal_ready_o;
  logic [3:0] bal_id_i = 4'd0;
  logic [0:0] bal_vote_i = 1'b0;
  logic       res_valid_o;
  logic       res_ready_i = 1'b0;
  logic       res_win_o;
  logic [3:0] res_yes_o;
  logic [3:0] res_no_o;
  logic [3:0] res_rej_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  // Model of the election: phase 0 = idle, 1 = collecting, 2 = reporting.
  int m_phase = 0;
  int m_yes = 0;
  int m_no = 0;
  int m_rej = 0;
  bit m_en = 1'b0;
  bit m_seen [16];

  voting_collector_n1_m4 dut (
    .clk         (clk),
    .rst         (rst),
    .open_i      (open_i),
    .en_i        (en_i),
    .close_i     (close_i),
    .bal_valid_i (bal_valid_i),
    .bal_ready_o (bal_ready_o),
    .bal_id_i    (bal_id_i),
    .bal_vote_i  (bal_vote_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_win_o   (res_win_o),
    .res_yes_o   (res_yes_o),
    .res_no_o    (res_no_o),
    .res_rej_o   (res_rej_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_yes = 0;
    m_no  = 0;
    m_rej = 0;
    for (int i = 0; i < 16; i++) m_seen[i] = 1'b0;
  endtask

  task automatic model_update(input bit r, input bit op, input bit en, input bit cl,
                              input bit v, input int id, input bit vote, input bit rdy);
    if (r) begin
      m_phase = 0;
      m_en    = 1'b0;
      model_clear();
    end else if (m_phase == 0) begin
      if (op) begin
        m_phase = 1;
        m_en    = en;
        model_clear();
      end
    end else if (m_phase == 1) begin
      if (v) begin
        if (id == 0 || m_seen[id]) begin
          if (m_rej < 15) m_rej++;
        end else begin
          m_seen[id] = 1'b1;
          if (vote) m_yes++;
          else      m_no++;
        end
      end
      if (cl || (m_yes + m_no == 15)) m_phase = 2;
    end else begin
      if (rdy) m_phase = 0;
    end
  endtask

  task automatic step(input bit r, input bit op, input bit en, input bit cl,
                      input bit v, input int id, input bit vote, input bit rdy);
    rst         = r;
    open_i      = op;
    en_i        = en;
    close_i     = cl;
    bal_valid_i = v;
    bal_id_i    = 4'(id);
    bal_vote_i  = vote;
    res_ready_i = rdy;
    model_update(r, op, en, cl, v, id, vote, rdy);
    @(posedge clk);
    #1;
    $display("step rst=%0b open=%0b en=%0b close=%0b valid=%0b id=%0d vote=%0b rdy=%0b -> valid=%0b yes=%0d no=%0d rej=%0d win=%0b",
             r, op, en, cl, v, id, vote, rdy, res_valid_o, res_yes_o, res_no_o, res_rej_o, res_win_o);
    chk("bal_ready", 32'(bal_ready_o), 32'(m_phase == 1));
    chk("res_valid", 32'(res_valid_o), 32'(m_phase == 2));
    chk("busy",      32'(busy_o),      32'(m_phase != 0));
    chk("res_yes",   32'(res_yes_o),   32'(m_yes));
    chk("res_no",    32'(res_no_o),    32'(m_no));
    chk("res_rej",   32'(res_rej_o),   32'(m_rej));
    chk("res_win",   32'(res_win_o),   32'(m_phase == 2 && m_en && m_yes > m_no));
  endtask

  task automatic t_rst();                        step(1, 0, 0, 0, 0, 0, 0, 0);  endtask
  task automatic t_open(input bit en);           step(0, 1, en, 0, 0, 0, 0, 0); endtask
  task automatic t_bal(input int id, input bit vote); step(0, 0, 0, 0, 1, id, vote, 0); endtask
  task automatic t_close();                      step(0, 0, 0, 1, 0, 0, 0, 0);  endtask
  task automatic t_idle(input bit rdy);          step(0, 0, 0, 0, 0, 0, 0, rdy); endtask

  initial begin
    // Basic election: 2 yes, 1 no, carried.
    t_rst();
    t_open(1);
    t_bal(1, 1);
    t_bal(2, 1);
    t_bal(3, 0);
    t_close();
    chk("seq1_win", 32'(res_win_o), 32'd1);
    chk("seq1_yes", 32'(res_yes_o), 32'd2);
    t_idle(1);

    // Duplicate and reserved id rejected; tie loses.
    t_open(1);
    t_bal(4, 1);
    t_bal(4, 0);
    t_bal(0, 1);
    t_bal(5, 0);
    t_close();
    chk("seq2_rej", 32'(res_rej_o), 32'd2);
    chk("seq2_win", 32'(res_win_o), 32'd0);
    t_idle(1);

    // Disabled election never carries.
    t_open(0);
    t_bal(6, 1);
    t_bal(7, 1);
    t_bal(8, 1);
    t_close();
    chk("seq3_win", 32'(res_win_o), 32'd0);
    t_idle(1);

    // Auto-close after the 15th unique ballot; a 16th is refused.
    t_open(1);
    for (int i = 1; i <= 15; i++) t_bal(i, 1);
    chk("seq4_valid", 32'(res_valid_o), 32'd1);
    chk("seq4_yes",   32'(res_yes_o),   32'd15);
    t_bal(3, 0);
    chk("seq4_no_accept", 32'(res_no_o), 32'd0);

    // Result held while the consumer stalls, then released.
    for (int i = 0; i < 5; i++) t_idle(0);
    t_idle(1);
    chk("seq5_busy", 32'(busy_o), 32'd0);

    // Reset mid-collection discards the election; reopen starts fresh.
    t_open(1);
    t_bal(1, 1);
    t_bal(2, 0);
    t_bal(3, 1);
    t_rst();
    t_open(1);
    t_bal(1, 0);
    t_close();
    chk("seq6_no", 32'(res_no_o), 32'd1);
    t_idle(1);

    // Close coincident with a ballot: ballot counts first.
    t_open(1);
    step(0, 0, 0, 1, 1, 9, 1, 0);
    chk("close_with_ballot", 32'(res_yes_o), 32'd1);
    t_idle(1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 70,
           int'($urandom_range(0, 15)),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 99) < 35);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
